// File: rtl/fb_pipe_stage.sv
// fb_pipe_stage: generic pipeline boundary register with valid/ready handshake,
// flush-to-bubble, hazard lock and a 2-entry skid buffer so that in_ready never
// depends combinationally on out_ready.
// Optional build macro FB_PIPE_STALL_CNT_EN enables the downstream back-pressure
// counter on stall_cnt; without it stall_cnt is tied to zero.
module fb_pipe_stage #(
  parameter int                DATA_W = 96,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              lock,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       stall_cnt
);

  // Occupancy is carried directly by the two valid bits; (0,1) cannot occur.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b10,
    SKID  = 2'b11
  } state_t;

  logic              main_v;
  logic              skid_v;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_d;
  logic              in_fire;
  logic              out_fire;
  state_t            state;

  assign state     = state_t'({main_v, skid_v});
  assign in_ready  = !skid_v && !lock;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_v && out_ready && !lock;
  assign out_valid = main_v;
  assign out_data  = main_d;

  // Main/skid occupancy and payload update; empty slots always hold BUBBLE.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= BUBBLE;
      skid_d <= BUBBLE;
    end else if (!lock) begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_v <= 1'b1;
            main_d <= in_data;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_d <= in_data;
          end else if (out_fire) begin
            main_v <= 1'b0;
            main_d <= BUBBLE;
          end else if (in_fire) begin
            skid_v <= 1'b1;
            skid_d <= in_data;
          end
        end
        SKID: begin
          if (out_fire) begin
            main_d <= skid_d;
            skid_v <= 1'b0;
            skid_d <= BUBBLE;
          end
        end
        default: begin
          // Unreachable occupancy: drop the orphaned skid entry.
          skid_v <= 1'b0;
          skid_d <= BUBBLE;
        end
      endcase
    end
  end

`ifdef FB_PIPE_STALL_CNT_EN
  logic [31:0] stall_q;

  // Count cycles where a valid entry is held back by downstream, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 32'h0;
    end else if (main_v && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'h1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule
